// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg
//   Shared definitions for the ADC MUX sequencer slice: the one-hot state
//   encoding, default timing constants and small elaboration-time helpers
//   used to size counters.
package adc_seq_pkg;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_MUX   = 7'b0000010,
    S_LEAD  = 7'b0000100,
    S_CP_HI = 7'b0001000,
    S_CP_LO = 7'b0010000,
    S_GAP   = 7'b0100000,
    S_HOLD  = 7'b1000000
  } state_t;

  localparam int unsigned DEF_COL_NUM     = 43;
  localparam int unsigned DEF_ROW_NUM     = 320;
  localparam int unsigned DEF_CP_HIGH     = 20;
  localparam int unsigned DEF_CP_LOW      = 20;
  localparam int unsigned DEF_MUX_LEAD    = 2;
  localparam int unsigned DEF_ROW_GAP     = 16;
  localparam int unsigned DEF_ADC_DIV     = 2;
  localparam int unsigned DEF_ACK_TIMEOUT = 1024;

  // Number of bits needed to count 0..v-1, never less than 1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_inclk_div.sv
// adc_inclk_div
//   Free-running ADC input clock generator. ADC_INCLK toggles every ADC_DIV
//   clk_100 cycles, giving a 50% duty clock of period 2*ADC_DIV. It starts
//   low and runs from reset release regardless of sequencer activity.
// Ports:
//   clk_100   in   system clock
//   rst       in   asynchronous reset, active-high
//   ADC_INCLK out  divided clock (registered)
module adc_inclk_div
  import adc_seq_pkg::*;
#(
  parameter int unsigned ADC_DIV = DEF_ADC_DIV
) (
  input  logic clk_100,
  input  logic rst,
  output logic ADC_INCLK
);

  localparam int unsigned     DIV_W    = clog2_min1(ADC_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ADC_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      div_cnt   <= '0;
      ADC_INCLK <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      ADC_INCLK <= ~ADC_INCLK;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_mux_sequencer.sv
// adc_mux_sequencer
//   Row/column timing generator for the ADC readout stage. Each row starts
//   with a one-cycle MUX_START, followed after MUX_LEAD cycles by COL_NUM
//   CP_MUX_IN pulses. Every pulse stays high for at least CP_HIGH cycles and
//   until the readout stage acknowledges the column on col_save. Rows are
//   held back while the RAM FIFO reports full. ADC_INCLK runs continuously.
// Ports:
//   clk_100     in   system clock
//   rst         in   asynchronous reset, active-high
//   en          in   sequencer enable (needed to start; low aborts at row end)
//   frame_start in   one-cycle frame start request, honoured only when idle
//   col_save    in   column-saved acknowledge
//   fifo_full   in   RAM FIFO full, checked only between rows
//   err_clr     in   clears timeout_err
//   MUX_START   out  row start pulse
//   CP_MUX_IN   out  column pulse
//   ADC_INCLK   out  ADC input clock
//   busy        out  high while a frame is in progress
//   frame_done  out  one-cycle pulse on normal frame completion
//   row_idx     out  current row
//   col_idx     out  current column
//   timeout_err out  sticky acknowledge-timeout flag
module adc_mux_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned COL_NUM     = DEF_COL_NUM,
  parameter int unsigned ROW_NUM     = DEF_ROW_NUM,
  parameter int unsigned CP_HIGH     = DEF_CP_HIGH,
  parameter int unsigned CP_LOW      = DEF_CP_LOW,
  parameter int unsigned MUX_LEAD    = DEF_MUX_LEAD,
  parameter int unsigned ROW_GAP     = DEF_ROW_GAP,
  parameter int unsigned ADC_DIV     = DEF_ADC_DIV,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        en,
  input  logic        frame_start,
  input  logic        col_save,
  input  logic        fifo_full,
  input  logic        err_clr,
  output logic        MUX_START,
  output logic        CP_MUX_IN,
  output logic        ADC_INCLK,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] row_idx,
  output logic [7:0]  col_idx,
  output logic        timeout_err
);

  // One shared phase counter serves every timed state; it is sized for the
  // longest interval it must count.
  localparam int unsigned MAX_T = max_u(max_u(max_u(MUX_LEAD, ROW_GAP),
                                              max_u(CP_HIGH, CP_LOW)),
                                        ACK_TIMEOUT);
  localparam int unsigned CNT_W = clog2_min1(MAX_T);

  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(MUX_LEAD - 1);
  localparam logic [CNT_W-1:0] HI_MIN    = CNT_W'(CP_HIGH - 1);
  localparam logic [CNT_W-1:0] LO_LAST   = CNT_W'(CP_LOW - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(ROW_GAP - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [7:0]       COL_LAST  = 8'(COL_NUM - 1);
  localparam logic [15:0]      ROW_LAST  = 16'(ROW_NUM - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ack_seen;
  logic             abort_flag;
  logic             ack_now;

  // Acknowledge either remembered from earlier in this pulse or arriving now.
  assign ack_now = ack_seen | col_save;

  adc_inclk_div #(
    .ADC_DIV (ADC_DIV)
  ) u_inclk_div (
    .clk_100   (clk_100),
    .rst       (rst),
    .ADC_INCLK (ADC_INCLK)
  );

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ack_seen    <= 1'b0;
      abort_flag  <= 1'b0;
      MUX_START   <= 1'b0;
      CP_MUX_IN   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      row_idx     <= '0;
      col_idx     <= '0;
      timeout_err <= 1'b0;
    end else begin
      MUX_START  <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= cnt + 1'b1;

      // A timeout set later in this block overrides the clear.
      if (err_clr) timeout_err <= 1'b0;

      // Dropping en only marks the frame; the row in flight still finishes.
      if ((state != S_IDLE) && !en) abort_flag <= 1'b1;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (frame_start && en) begin
            state      <= S_HOLD;
            busy       <= 1'b1;
            row_idx    <= '0;
            col_idx    <= '0;
            abort_flag <= 1'b0;
          end
        end

        S_HOLD: begin
          cnt <= '0;
          if (!fifo_full) begin
            state     <= S_MUX;
            MUX_START <= 1'b1;
          end
        end

        S_MUX: begin
          state <= S_LEAD;
          cnt   <= '0;
        end

        S_LEAD: begin
          if (cnt == LEAD_LAST) begin
            state     <= S_CP_HI;
            CP_MUX_IN <= 1'b1;
            ack_seen  <= 1'b0;
            cnt       <= '0;
          end
        end

        S_CP_HI: begin
          if (col_save) ack_seen <= 1'b1;
          if ((cnt >= HI_MIN) && ack_now) begin
            state     <= S_CP_LO;
            CP_MUX_IN <= 1'b0;
            cnt       <= '0;
          end else if (cnt == TMO_LAST) begin
            // Readout never answered: give up on the frame entirely.
            state       <= S_IDLE;
            CP_MUX_IN   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end
        end

        S_CP_LO: begin
          if (cnt == LO_LAST) begin
            cnt <= '0;
            if (col_idx < COL_LAST) begin
              col_idx   <= col_idx + 1'b1;
              state     <= S_CP_HI;
              CP_MUX_IN <= 1'b1;
              ack_seen  <= 1'b0;
            end else begin
              state <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (abort_flag) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (row_idx == ROW_LAST) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              row_idx <= row_idx + 1'b1;
              col_idx <= '0;
              state   <= S_HOLD;
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          CP_MUX_IN <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule
